// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and overflow/underflow error pulses.
//
// Ports:
//   CLK          - system clock, all state updates on rising edge
//   Reset        - synchronous, active-high reset (priority over all inputs)
//   Write_En     - write request
//   Data_In      - write data (WIDTH bits)
//   Read_En      - read request
//   Data_Out     - registered read data, one cycle after the accepting edge
//   Valid        - Data_Out holds a newly read word this cycle
//   Empty        - Count == 0
//   Full         - Count == DEPTH
//   Almost_Empty - Count <= AE_LEVEL
//   Almost_Full  - Count >= AF_LEVEL
//   Count        - current occupancy, 0..DEPTH
//   Overflow     - one-cycle pulse after a rejected write
//   Underflow    - one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   Write_En,
  input  logic [WIDTH-1:0]       Data_In,
  input  logic                   Read_En,
  output logic [WIDTH-1:0]       Data_Out,
  output logic                   Valid,
  output logic                   Empty,
  output logic                   Full,
  output logic                   Almost_Empty,
  output logic                   Almost_Full,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

  // Storage and registered state
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_data_out;
  logic             r_valid;
  logic             r_overflow;
  logic             r_underflow;

  // Decoded status and handshakes
  logic [PW-1:0]    w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_ok;
  logic             w_wr_ok;

  // Status decode: pointers carry a wrap bit so equal low bits disambiguate
  // full (wrap bits differ) from empty (wrap bits equal).
  always_comb begin
    w_count = r_wr_ptr - r_rd_ptr;
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
              (r_wr_ptr[AW] != r_rd_ptr[AW]);
    w_rd_ok = Read_En & ~w_empty;
    // A full FIFO still accepts a write when a read frees a slot this cycle.
    w_wr_ok = Write_En & (~w_full | w_rd_ok);
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge CLK) begin
    if (!Reset && w_wr_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= Data_In;
    end
  end

  // Pointers, read data and error pulses
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      // When full with a simultaneous write, the read sees the old word
      // before the write overwrites the same slot.
      if (w_rd_ok) begin
        r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr   <= r_rd_ptr + PW'(1);
      end
      r_valid     <= w_rd_ok;
      r_overflow  <= Write_En & ~w_wr_ok;
      r_underflow <= Read_En & w_empty;
    end
  end

  assign Data_Out     = r_data_out;
  assign Valid        = r_valid;
  assign Overflow     = r_overflow;
  assign Underflow    = r_underflow;
  assign Count        = w_count;
  assign Empty        = w_empty;
  assign Full         = w_full;
  assign Almost_Empty = (w_count <= AE_CNT);
  assign Almost_Full  = (w_count >= AF_CNT);

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO; next generation of the team's 32x8 single-port FIFO.
- Configurable width and depth.
- Independent read and write enables, so a read and a write can both complete in the same cycle.
- Occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
- Sits between producer and consumer datapath blocks in one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 32, number of entries; power of two, >=4
AF_LEVEL, DEPTH-4, Almost_Full asserted when Count >= AF_LEVEL
AE_LEVEL, 4, Almost_Empty asserted when Count <= AE_LEVEL

Ports:
CLK  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Write_En  input  1  write request
Data_In  input  WIDTH  write data
Read_En  input  1  read request
Data_Out  output  WIDTH  registered read data
Valid  output  1  Data_Out holds a newly read word this cycle
Empty  output  1  Count == 0
Full  output  1  Count == DEPTH
Almost_Empty  output  1  Count <= AE_LEVEL
Almost_Full  output  1  Count >= AF_LEVEL
Count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
Overflow  output  1  one-cycle pulse: write rejected
Underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset is sampled on the CLK edge and has priority over all other inputs.
- Values after reset:
  - pointers = 0, Count = 0, Empty = 1, Full = 0, Almost_Empty = 1, Almost_Full = 0;
  - Data_Out = 0, Valid = 0, Overflow = 0, Underflow = 0;
  - memory contents are not cleared.
- Reset asserted mid-operation discards all stored data; the first cycle after Reset deasserts behaves exactly like the post-reset state.
- Pointers:
  - write and read pointers are clog2(DEPTH)+1 bits wide;
  - the low bits address memory; the MSB is a wrap bit;
  - Empty when the pointers are equal including the wrap bit; Full when the low bits are equal and the wrap bits differ.
- Count equals wr_ptr - rd_ptr, modulo 2^(clog2(DEPTH)+1).
- All flags are derived from registered state and are valid in the same cycle as Count; they never lag.
- Write acceptance:
  - wr_ok = Write_En & (~Full | rd_ok);
  - on wr_ok, mem[wr_ptr] <= Data_In and wr_ptr increments.
- Read acceptance:
  - rd_ok = Read_En & ~Empty;
  - on rd_ok, Data_Out <= mem[rd_ptr], rd_ptr increments, and Valid = 1 in the next cycle;
  - read latency is 1 cycle from the accepting edge.
- With no accepted read, Data_Out holds its last value and Valid = 0.
- Simultaneous Write_En and Read_En:
  - not empty (including full): both accepted, Count unchanged.
  - empty: write accepted, read rejected (no fall-through), Underflow pulses.
- Rejected write (Write_En & Full & ~rd_ok):
  - data dropped, state unchanged;
  - Overflow = 1 for exactly the next cycle.
- Rejected read (Read_En & Empty):
  - state unchanged, Valid = 0;
  - Underflow = 1 for exactly the next cycle.
- Overflow and Underflow are registered pulses, not sticky.
- Wrap-around: pointers roll over modulo 2*DEPTH with no bubble, and data order is preserved across the wrap.
- Count transitions per cycle:
  - +1 on write only;
  - -1 on read only;
  - 0 on both or neither.

Test Plan:
(All with WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=4.)
1. Reset, then write 0x01..0x10 in 16 consecutive cycles -> Full=1 and Count=16 after the 16th edge; Almost_Full=1 from Count=12; Empty=0 after the 1st edge.
2. When full, one more write of 0xAA -> Overflow pulses 1 cycle, Count stays 16; then 16 reads -> Data_Out sequence 0x01..0x10 each 1 cycle after its read, Valid high 16 cycles, then Empty=1.
3. When empty, Read_En -> Underflow pulses 1 cycle, Valid=0, Data_Out unchanged, Count=0.
4. Full FIFO, Write_En=Read_En=1 with Data_In=0x55 -> Count stays 16, Data_Out=0x01, no Overflow; 0x55 is later read out 16th.
5. Empty FIFO, Write_En=Read_En=1 with 0x33 -> Count=1, Underflow=1, Valid=0; next cycle read -> Data_Out=0x33.
6. Stream 40 words 0x00..0x27 with reads lagging writes by 3 (wrap crossed twice) -> output order exact, Count peaks at 3; then Reset mid-stream -> Count=0, Empty=1, Valid=0 on the next cycle.
